decode_issue_stage: RTL
=======================

// Module: decode_issue_stage
// PURPOSE
//  RV32I decode/issue stage: holds the IF/ID register, drives rs1/rs2 to the register file and
//  receives its bypassed read data. Resolves operands (EX > MEM > regfile forwarding), detects
//  load-use hazards, inserts bubbles and flushes. Launches decoded instructions into the ID/EX register.
// PARAMETERS
//  XLEN        32  datapath/PC width
//  STALL_CNT_W 32  width of saturating stall-cycle counter
// PORTS
//  clk          in   1     clock
//  rst          in   1     reset, synchronous, active-high
//  pipeline_en  in   1     global advance enable; 0 = every register holds
//  flush        in   1     taken branch/jump resolved in EX; kill IF/ID and ID/EX
//  if_valid     in   1     fetch offers if_instr/if_pc
//  if_instr     in   32    fetched instruction
//  if_pc        in   XLEN  its PC
//  id_ready     out  1     IF/ID can accept (fetch must hold when 0)
//  rs1, rs2     out  5     register file read addresses (from IF/ID instr; 0 if unused)
//  rf_reg1/2    in   XLEN  register file read data (already WB-bypassed)
//  ex_fwd_data  in   XLEN  ALU result of instruction currently in ID/EX
//  mem_rd       in   5     MEM-stage destination
//  mem_wen      in   1     MEM-stage writes mem_rd
//  mem_data     in   XLEN  MEM-stage result (load data resolved)
//  ex_valid     out  1     ID/EX holds a real instruction
//  ex_pc, ex_imm out XLEN  PC and sign-extended immediate
//  ex_instr     out  32    raw instruction (funct3/funct7 for EX)
//  ex_op1/2     out  XLEN  resolved rs1/rs2 operands
//  ex_rd        out  5     destination; ex_wen 1 writes rd; ex_is_load 1 LOAD; ex_illegal 1 bad opcode
//  stall_cnt    out  STALL_CNT_W  count of bubble-inserting cycles, saturates at all-ones
// BEHAVIOUR
//  - Reset: IF/ID and ID/EX valid=0, all ex_* data 0, stall_cnt=0; id_ready=1 after reset.
//  - pipeline_en=0: nothing changes (flush, stall counting, capture all ignored).
//  - Latency: instruction accepted at edge N (if_valid & id_ready) appears on ex_* at edge N+1.
//  - Decode use: LUI/AUIPC/JAL none; JALR/LOAD/OP-IMM rs1; BRANCH/STORE/OP rs1+rs2.
//    wen for LUI,AUIPC,JAL,JALR,LOAD,OP-IMM,OP and rd!=0. Other opcodes: illegal=1, wen=0, no uses.
//  - Imm: I/S/B/U/J formats per opcode, sign-extended to XLEN; R-type imm=0.
//  - Hazard (ID valid): used rs!=0 matching ex_rd with ex_valid&ex_wen&ex_is_load -> stall.
//  - Stall: IF/ID held, id_ready=0, ID/EX loads bubble (ex_valid=0), stall_cnt+1 (saturating).
//    A load-use stall lasts exactly one cycle; the load then sits in MEM and forwards from mem_data.
//  - Operand select per source: rs==0 -> 0; EX match (ex_valid&ex_wen&ex_rd==rs) -> ex_fwd_data;
//    else MEM match (mem_wen&mem_rd==rs) -> mem_data; else rf_reg*. EX beats MEM on equal rd.
//  - Flush: IF/ID valid<=0 and ID/EX valid<=0 next edge; overrides stall and capture; no stall count.
//  - id_ready = !stall (flush does not drop id_ready; fetch redirect is fetch's job).
//  - Reset mid-stall or mid-flush: reset wins, state returns to reset values.
// CONFIGURATION
//  FWD_EX_EN defined: EX->ID forwarding of ex_fwd_data as above.
//  FWD_EX_EN undefined: no EX forwarding; any non-load EX rd match also stalls one cycle
//    (counted), operand then taken from MEM path. ex_fwd_data unused.
// STRUCTURE
//  Package rv32_pkg: opcode enum (LUI..SYSTEM), imm-format enum, instruction field slice functions,
//    id_ex_t packed struct for the ID/EX register.
//  Sub-module rv32_imm_gen: combinational instr -> {fmt, imm}; instantiated once.
// TESTING
//  1 reset 2 cycles -> ex_valid=0, id_ready=1, stall_cnt=0, ex_op1=0.
//  2 addi x1,x0,5 then add x2,x1,x1, ex_fwd_data=5 -> next cycle ex_op1=ex_op2=5, no bubble;
//    without FWD_EX_EN -> one bubble, stall_cnt=1, then ops=mem_data=5.
//  3 lw x3,0(x0) then add x4,x3,x0, mem_data=0x1234 -> one ex_valid=0 cycle, stall_cnt=1,
//    then ex_op1=0x1234, ex_op2=0.
//  4 flush during load-use stall -> next edge ex_valid=0, IF/ID empty, id_ready=1, stall_cnt unchanged.
//  5 pipeline_en=0 for 3 cycles with flush=1 and if_valid=1 -> all ex_* and stall_cnt hold.
//  6 mem_rd=ex_rd=5 both writing, ex_fwd_data=7, mem_data=9, dependent add -> ex_op1=7 (EX priority).

Source files
------------

// File: rtl/rv32_pkg.sv
// RV32I shared types: opcodes, immediate formats, field slicers, ID/EX bundle.
// Imported by decode_issue_stage and rv32_imm_gen.
package rv32_pkg;

  localparam int RV_XLEN = 32;

  typedef enum logic [6:0] {
    OPC_LUI      = 7'b0110111,
    OPC_AUIPC    = 7'b0010111,
    OPC_JAL      = 7'b1101111,
    OPC_JALR     = 7'b1100111,
    OPC_BRANCH   = 7'b1100011,
    OPC_LOAD     = 7'b0000011,
    OPC_STORE    = 7'b0100011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_OP       = 7'b0110011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] imm;
    logic [31:0]        instr;
    logic [RV_XLEN-1:0] op1;
    logic [RV_XLEN-1:0] op2;
    logic [4:0]         rd;
    logic               wen;
    logic               is_load;
    logic               illegal;
  } id_ex_t;

  function automatic logic [6:0] f_opcode(input logic [31:0] i);
    return i[6:0];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] i);
    return i[11:7];
  endfunction

  function automatic logic [4:0] f_rs1(input logic [31:0] i);
    return i[19:15];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [31:0] i);
    return i[24:20];
  endfunction

  // FENCE and SYSTEM are outside the supported set and map to FMT_NONE.
  function automatic imm_fmt_e f_fmt(input logic [6:0] op);
    imm_fmt_e fmt;
    case (op)
      OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
      OPC_JAL:                        fmt = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = FMT_I;
      OPC_STORE:                      fmt = FMT_S;
      OPC_BRANCH:                     fmt = FMT_B;
      OPC_OP:                         fmt = FMT_R;
      default:                        fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational immediate generator: instr -> {format, sign-extended imm}.
// Ports: i_instr in; o_fmt, o_imm out (imm is 0 for R-type and unknown opcodes).
module rv32_imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0]        i_instr,
  output imm_fmt_e           o_fmt,
  output logic [RV_XLEN-1:0] o_imm
);

  logic [31:0] w_i;
  logic [31:0] w_imm;

  assign w_i   = i_instr;
  assign o_fmt = f_fmt(f_opcode(w_i));

  always_comb begin
    w_imm = '0;
    unique case (o_fmt)
      FMT_I: w_imm = {{20{w_i[31]}}, w_i[31:20]};
      FMT_S: w_imm = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
      FMT_B: w_imm = {{19{w_i[31]}}, w_i[31], w_i[7],
                      w_i[30:25], w_i[11:8], 1'b0};
      FMT_U: w_imm = {w_i[31:12], 12'b0};
      FMT_J: w_imm = {{11{w_i[31]}}, w_i[31], w_i[19:12],
                      w_i[20], w_i[30:21], 1'b0};
      FMT_R,
      FMT_NONE: w_imm = '0;
      default:  w_imm = '0;
    endcase
  end

  assign o_imm = w_imm;

endmodule

// File: rtl/decode_issue_stage.sv
// RV32I decode/issue: IF/ID reg, operand forwarding, load-use stall, flush, ID/EX reg.
// Macro FWD_EX_EN enables EX->ID forwarding; otherwise any EX rd match stalls one cycle.
module decode_issue_stage
  import rv32_pkg::*;
#(
  parameter int XLEN        = RV_XLEN,
  parameter int STALL_CNT_W = 32
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipeline_en,
  input  logic                   flush,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  input  logic [XLEN-1:0]        if_pc,
  output logic                   id_ready,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  input  logic [XLEN-1:0]        rf_reg1,
  input  logic [XLEN-1:0]        rf_reg2,
  input  logic [XLEN-1:0]        ex_fwd_data,
  input  logic [4:0]             mem_rd,
  input  logic                   mem_wen,
  input  logic [XLEN-1:0]        mem_data,
  output logic                   ex_valid,
  output logic [XLEN-1:0]        ex_pc,
  output logic [XLEN-1:0]        ex_imm,
  output logic [31:0]            ex_instr,
  output logic [XLEN-1:0]        ex_op1,
  output logic [XLEN-1:0]        ex_op2,
  output logic [4:0]             ex_rd,
  output logic                   ex_wen,
  output logic                   ex_is_load,
  output logic                   ex_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic                   r_id_valid;
  logic [31:0]            r_id_instr;
  logic [XLEN-1:0]        r_id_pc;
  id_ex_t                 r_ex;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  imm_fmt_e        w_fmt;
  logic [XLEN-1:0] w_imm;
  logic            w_use1;
  logic            w_use2;
  logic            w_ill;
  logic            w_wen;
  logic            w_ex_hit1;
  logic            w_ex_hit2;
  logic            w_haz1;
  logic            w_haz2;
  logic            w_fwd1;
  logic            w_fwd2;
  logic [XLEN-1:0] w_fwd_data;
  logic            w_stall;
  id_ex_t          w_next;

  rv32_imm_gen u_imm_gen (
    .i_instr (r_id_instr),
    .o_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  assign w_ill = (w_fmt == FMT_NONE);

  always_comb begin
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    unique case (1'b1)
      (w_fmt == FMT_R),
      (w_fmt == FMT_S),
      (w_fmt == FMT_B): begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
      end
      (w_fmt == FMT_I): w_use1 = 1'b1;
      default: ;
    endcase
  end

  assign w_wen = !w_ill && (w_fmt != FMT_S) && (w_fmt != FMT_B)
              && (f_rd(r_id_instr) != 5'd0);

  assign rs1 = w_use1 ? f_rs1(r_id_instr) : 5'd0;
  assign rs2 = w_use2 ? f_rs2(r_id_instr) : 5'd0;

  assign w_ex_hit1 = r_ex.valid && r_ex.wen
                  && (rs1 != 5'd0) && (r_ex.rd == rs1);
  assign w_ex_hit2 = r_ex.valid && r_ex.wen
                  && (rs2 != 5'd0) && (r_ex.rd == rs2);

`ifdef FWD_EX_EN
  // Only a load in EX cannot forward; its data arrives from MEM a cycle later.
  assign w_haz1     = w_ex_hit1 && r_ex.is_load;
  assign w_haz2     = w_ex_hit2 && r_ex.is_load;
  assign w_fwd1     = w_ex_hit1;
  assign w_fwd2     = w_ex_hit2;
  assign w_fwd_data = ex_fwd_data;
`else
  logic w_unused;
  assign w_haz1     = w_ex_hit1;
  assign w_haz2     = w_ex_hit2;
  assign w_fwd1     = 1'b0;
  assign w_fwd2     = 1'b0;
  assign w_fwd_data = '0;
  assign w_unused   = ^ex_fwd_data;
`endif

  assign w_stall  = r_id_valid && (w_haz1 || w_haz2);
  assign id_ready = !w_stall;

  function automatic logic [XLEN-1:0] f_sel(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf,
    input logic            fwd,
    input logic [XLEN-1:0] fwd_data,
    input logic            m_wen,
    input logic [4:0]      m_rd,
    input logic [XLEN-1:0] m_data
  );
    if (rs == 5'd0)                   return '0;
    else if (fwd)                     return fwd_data;
    else if (m_wen && (m_rd == rs))   return m_data;
    else                              return rf;
  endfunction

  always_comb begin
    w_next         = '0;
    w_next.valid   = 1'b1;
    w_next.pc      = r_id_pc;
    w_next.imm     = w_imm;
    w_next.instr   = r_id_instr;
    w_next.op1     = f_sel(rs1, rf_reg1, w_fwd1, w_fwd_data,
                           mem_wen, mem_rd, mem_data);
    w_next.op2     = f_sel(rs2, rf_reg2, w_fwd2, w_fwd_data,
                           mem_wen, mem_rd, mem_data);
    w_next.rd      = w_wen ? f_rd(r_id_instr) : 5'd0;
    w_next.wen     = w_wen;
    w_next.is_load = (f_opcode(r_id_instr) == OPC_LOAD);
    w_next.illegal = w_ill;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_valid  <= 1'b0;
      r_id_instr  <= '0;
      r_id_pc     <= '0;
      r_ex        <= '0;
      r_stall_cnt <= '0;
    end else if (pipeline_en) begin
      if (flush) begin
        r_id_valid <= 1'b0;
        r_ex       <= '0;
      end else if (w_stall) begin
        r_ex <= '0;
        if (r_stall_cnt != '1)
          r_stall_cnt <= r_stall_cnt + 1'b1;
      end else begin
        r_ex       <= r_id_valid ? w_next : '0;
        r_id_valid <= if_valid;
        if (if_valid) begin
          r_id_instr <= if_instr;
          r_id_pc    <= if_pc;
        end
      end
    end
  end

  assign ex_valid   = r_ex.valid;
  assign ex_pc      = r_ex.pc;
  assign ex_imm     = r_ex.imm;
  assign ex_instr   = r_ex.instr;
  assign ex_op1     = r_ex.op1;
  assign ex_op2     = r_ex.op2;
  assign ex_rd      = r_ex.rd;
  assign ex_wen     = r_ex.wen;
  assign ex_is_load = r_ex.is_load;
  assign ex_illegal = r_ex.illegal;
  assign stall_cnt  = r_stall_cnt;

endmodule
